// File: rtl/lpc_dec_if.sv
// Bus bundle for the LPC speech decoder: frame parameters, sample request and synthesized output.
interface lpc_dec_if;
   logic signed [15:0] A1;
   logic signed [15:0] A2;
   logic signed [15:0] A3;
   logic signed [15:0] A4;
   logic signed [15:0] A5;
   logic signed [15:0] A6;
   logic signed [15:0] A7;
   logic signed [15:0] A8;
   logic signed [15:0] A9;
   logic signed [15:0] A10;
   logic               voiced;
   logic [15:0]        freq_count;
   logic               load;
   logic               v;
   logic signed [15:0] y;
   logic               vout;
   logic               ovr;

   modport master (
      output A1, A2, A3, A4, A5, A6, A7, A8, A9, A10,
      output voiced, freq_count, load, v,
      input  y, vout, ovr
   );

   modport slave (
      input  A1, A2, A3, A4, A5, A6, A7, A8, A9, A10,
      input  voiced, freq_count, load, v,
      output y, vout, ovr
   );
endinterface

// File: rtl/lpc_dec.sv
// 10-tap LPC all-pole synthesis filter, one shared multiplier, pulse/noise excitation.
// Optional output de-emphasis stage enabled by defining LPC_DEC_DEEMPH_EN.
module lpc_dec #(
   parameter logic signed [15:0] PULSE_AMP   = 16'sd8192,
   parameter int                 NOISE_SHIFT = 3
) (
   input  logic      clk,
   input  logic      rst,
   lpc_dec_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_accept;
   logic               w_out_first;

   logic signed [15:0] w_a_in [0:9];
   logic signed [15:0] r_a_sh [0:9];
   logic               r_voiced_sh;
   logic [15:0]        r_fc_sh;
   logic signed [15:0] r_a    [0:9];
   logic               r_voiced;
   logic [15:0]        r_fc;

   logic signed [15:0] r_hist [0:9];
   logic [15:0]        r_pcnt;
   logic [15:0]        r_lfsr;
   logic [3:0]         r_tap;
   logic signed [39:0] r_acc;
   logic signed [15:0] r_sat;
   logic               r_p1;
   logic signed [15:0] r_y;
   logic               r_vout;
   logic               r_ovr;

   logic signed [15:0] w_e;
   logic [15:0]        w_pcnt_nxt;
   logic [15:0]        w_lfsr_nxt;
   logic signed [39:0] w_e_ext;
   logic signed [31:0] w_prod;
   logic signed [39:0] w_prod_ext;

`ifdef LPC_DEC_DEEMPH_EN
   logic               r_p2;
   logic               r_ocnt;
   logic signed [18:0] w_d7;
   logic signed [18:0] w_d7s;
   logic signed [39:0] w_dsum;
`endif

   function automatic logic signed [15:0] sat16(input logic signed [39:0] x);
      logic signed [15:0] r;
      if (x > 40'sd32767) begin
         r = 16'sh7FFF;
      end else if (x < -40'sd32768) begin
         r = 16'sh8000;
      end else begin
         r = x[15:0];
      end
      return r;
   endfunction

   assign w_a_in[0] = bus.A1;
   assign w_a_in[1] = bus.A2;
   assign w_a_in[2] = bus.A3;
   assign w_a_in[3] = bus.A4;
   assign w_a_in[4] = bus.A5;
   assign w_a_in[5] = bus.A6;
   assign w_a_in[6] = bus.A7;
   assign w_a_in[7] = bus.A8;
   assign w_a_in[8] = bus.A9;
   assign w_a_in[9] = bus.A10;

   assign w_prod     = r_a[r_tap] * r_hist[r_tap];
   assign w_prod_ext = $signed({{8{w_prod[31]}}, w_prod});
   assign w_e_ext    = $signed({{12{w_e[15]}}, w_e, 12'd0});

`ifdef LPC_DEC_DEEMPH_EN
   assign w_out_first = (r_state == OUT) && !r_ocnt;
   assign w_d7        = $signed({{3{r_y[15]}}, r_y}) * 19'sd7;
   assign w_d7s       = w_d7 >>> 3;
   assign w_dsum      = $signed({{24{r_sat[15]}}, r_sat}) + $signed({{21{w_d7s[18]}}, w_d7s});
`else
   assign w_out_first = (r_state == OUT);
`endif

   assign bus.y    = r_y;
   assign bus.vout = r_vout;
   assign bus.ovr  = r_ovr;

   // Next-state and request acceptance
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.v) begin
               w_accept    = 1'b1;
               w_state_nxt = MAC;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         MAC: begin
            if (r_tap == 4'd9) begin
               w_state_nxt = OUT;
            end else begin
               w_state_nxt = MAC;
            end
         end
         OUT: begin
`ifdef LPC_DEC_DEEMPH_EN
            if (r_ocnt) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = OUT;
            end
`else
            w_state_nxt = IDLE;
`endif
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Excitation sample and next pitch counter / LFSR values
   always_comb begin
      w_e        = 16'sd0;
      w_pcnt_nxt = r_pcnt;
      w_lfsr_nxt = r_lfsr;
      if (r_voiced) begin
         if (r_fc == 16'd0) begin
            w_pcnt_nxt = 16'd0;
         end else begin
            if (r_pcnt == 16'd0) begin
               w_e = PULSE_AMP;
            end else begin
               w_e = 16'sd0;
            end
            // >= keeps the counter bounded when a shorter period is loaded mid-cycle
            if (r_pcnt >= (r_fc - 16'd1)) begin
               w_pcnt_nxt = 16'd0;
            end else begin
               w_pcnt_nxt = r_pcnt + 16'd1;
            end
         end
      end else begin
         w_e        = $signed(r_lfsr) >>> NOISE_SHIFT;
         w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
   end

   // State register and sticky overrun flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (bus.v && (r_state != IDLE)) begin
            r_ovr <= 1'b1;
         end
      end
   end

   // Shadow parameter capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 10; i++) begin
            r_a_sh[i] <= 16'sd0;
         end
         r_voiced_sh <= 1'b0;
         r_fc_sh     <= 16'd0;
      end else if (bus.load) begin
         for (int i = 0; i < 10; i++) begin
            r_a_sh[i] <= w_a_in[i];
         end
         r_voiced_sh <= bus.voiced;
         r_fc_sh     <= bus.freq_count;
      end
   end

   // Active parameter copy, excitation advance and multiply-accumulate
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 10; i++) begin
            r_a[i] <= 16'sd0;
         end
         r_voiced <= 1'b0;
         r_fc     <= 16'd0;
         r_tap    <= 4'd0;
         r_acc    <= 40'sd0;
         r_pcnt   <= 16'd0;
         r_lfsr   <= 16'hACE1;
      end else if (w_accept) begin
         for (int i = 0; i < 10; i++) begin
            r_a[i] <= r_a_sh[i];
         end
         r_voiced <= r_voiced_sh;
         r_fc     <= r_fc_sh;
         r_tap    <= 4'd0;
      end else if (r_state == MAC) begin
         r_tap <= r_tap + 4'd1;
         // First tap seeds the accumulator with the scaled excitation
         if (r_tap == 4'd0) begin
            r_acc  <= w_e_ext - w_prod_ext;
            r_pcnt <= w_pcnt_nxt;
            r_lfsr <= w_lfsr_nxt;
         end else begin
            r_acc <= r_acc - w_prod_ext;
         end
      end
   end

   // Saturation, history shift and registered output
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sat  <= 16'sd0;
         r_p1   <= 1'b0;
         r_y    <= 16'sd0;
         r_vout <= 1'b0;
         for (int i = 0; i < 10; i++) begin
            r_hist[i] <= 16'sd0;
         end
`ifdef LPC_DEC_DEEMPH_EN
         r_p2   <= 1'b0;
         r_ocnt <= 1'b0;
`endif
      end else begin
         r_vout <= 1'b0;
         r_p1   <= w_out_first;
         if (w_out_first) begin
            r_sat <= sat16(r_acc >>> 12);
         end
         if (r_p1) begin
            r_hist[0] <= r_sat;
            for (int i = 1; i < 10; i++) begin
               r_hist[i] <= r_hist[i-1];
            end
`ifndef LPC_DEC_DEEMPH_EN
            r_y    <= r_sat;
            r_vout <= 1'b1;
`endif
         end
`ifdef LPC_DEC_DEEMPH_EN
         r_ocnt <= (r_state == OUT) && !r_ocnt;
         r_p2   <= r_p1;
         // r_y doubles as the de-emphasis state d[n-1]
         if (r_p2) begin
            r_y    <= sat16(w_dsum);
            r_vout <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_lpc_dec.sv
// Self-checking bench for lpc_dec: table-driven sample rows plus hand-written corner sequences.
module tb_lpc_dec;

`ifdef LPC_DEC_DEEMPH_EN
   localparam int LAT = 13;
`else
   localparam int LAT = 12;
`endif

   typedef struct {
      bit                 rst_first;
      bit                 do_load;
      logic signed [15:0] a1;
      logic               voiced;
      logic [15:0]        fc;
      int                 space;
      logic signed [15:0] exp_y;
   } vec_t;

   typedef struct {
      logic signed [15:0] y;
      int                 cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   failures;
   int   nvout;
   logic signed [15:0] dm;
   exp_t sbq[$];
   exp_t pe;
   vec_t tbl[$];

   lpc_dec_if bus();

   lpc_dec dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic signed [15:0] tb_sat(input longint x);
      if (x > 32767) return 16'sh7FFF;
      if (x < -32768) return 16'sh8000;
      return x[15:0];
   endfunction

   function automatic void push_exp(input logic signed [15:0] yraw);
      exp_t e;
`ifdef LPC_DEC_DEEMPH_EN
      dm = tb_sat(longint'(yraw) + ((longint'(7) * longint'(dm)) >>> 3));
      e.y = dm;
`else
      e.y = yraw;
`endif
      e.cyc = cyc + 1;
      sbq.push_back(e);
   endfunction

   function automatic void add(input bit r, input bit l, input logic signed [15:0] a1,
                               input logic vc, input logic [15:0] fc, input int sp,
                               input logic signed [15:0] ey);
      vec_t t;
      t.rst_first = r; t.do_load = l; t.a1 = a1; t.voiced = vc;
      t.fc = fc; t.space = sp; t.exp_y = ey;
      tbl.push_back(t);
   endfunction

   // Scoreboard: every vout pops one expectation and checks value and latency
   always @(negedge clk) begin
      if (bus.vout) begin
         nvout = nvout + 1;
         checks = checks + 1;
         if (sbq.size() == 0) begin
            failures = failures + 1;
            $display("FAIL unexpected_vout y=%0d", bus.y);
         end else begin
            pe = sbq.pop_front();
            if (bus.y !== pe.y) begin
               failures = failures + 1;
               $display("FAIL y_value got=%0d expected=%0d", bus.y, pe.y);
            end
            checks = checks + 1;
            if (cyc - pe.cyc != LAT) begin
               failures = failures + 1;
               $display("FAIL latency got=%0d expected=%0d", cyc - pe.cyc, LAT);
            end
         end
      end
   end

   task automatic check(input string name, input longint got, input longint expv);
      checks = checks + 1;
      if (got != expv) begin
         failures = failures + 1;
         $display("FAIL %s got=%0d expected=%0d", name, got, expv);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      dm = 16'sd0;
   endtask

   task automatic load_par(input logic signed [15:0] a1, input logic vc, input logic [15:0] fc);
      @(negedge clk);
      bus.A1 = a1; bus.A2 = 16'sd0; bus.A3 = 16'sd0; bus.A4 = 16'sd0; bus.A5 = 16'sd0;
      bus.A6 = 16'sd0; bus.A7 = 16'sd0; bus.A8 = 16'sd0; bus.A9 = 16'sd0; bus.A10 = 16'sd0;
      bus.voiced = vc; bus.freq_count = fc; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic req(input bit push, input logic signed [15:0] ey, input int space);
      @(negedge clk);
      bus.v = 1'b1;
      if (push) push_exp(ey);
      @(negedge clk);
      bus.v = 1'b0;
      repeat (space - 2) @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", sbq.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int nv0;
      checks = 0; failures = 0; nvout = 0; dm = 16'sd0;
      rst = 1'b0;
      bus.v = 1'b0; bus.load = 1'b0; bus.voiced = 1'b0; bus.freq_count = 16'd0;
      bus.A1 = 16'sd0; bus.A2 = 16'sd0; bus.A3 = 16'sd0; bus.A4 = 16'sd0; bus.A5 = 16'sd0;
      bus.A6 = 16'sd0; bus.A7 = 16'sd0; bus.A8 = 16'sd0; bus.A9 = 16'sd0; bus.A10 = 16'sd0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_y", bus.y, 0);
      check("reset_vout", bus.vout, 0);
      check("reset_ovr", bus.ovr, 0);

      // impulse train, period 4
      add(1, 1, 16'sd0, 1'b1, 16'd4, 16, 16'sd8192);
      add(0, 0, 16'sd0, 1'b1, 16'd4, 16, 16'sd0);
      add(0, 0, 16'sd0, 1'b1, 16'd4, 16, 16'sd0);
      add(0, 0, 16'sd0, 1'b1, 16'd4, 16, 16'sd0);
      add(0, 0, 16'sd0, 1'b1, 16'd4, 16, 16'sd8192);
      add(0, 0, 16'sd0, 1'b1, 16'd4, 16, 16'sd0);
      // one-pole decay
      add(1, 1, -16'sd2048, 1'b1, 16'd100, 14, 16'sd8192);
      add(0, 0, -16'sd2048, 1'b1, 16'd100, 14, 16'sd4096);
      add(0, 0, -16'sd2048, 1'b1, 16'd100, 14, 16'sd2048);
      add(0, 0, -16'sd2048, 1'b1, 16'd100, 14, 16'sd1024);
      add(0, 0, -16'sd2048, 1'b1, 16'd100, 14, 16'sd512);
      // saturating integrator at minimum spacing
      add(1, 1, -16'sd4096, 1'b1, 16'd1, 12, 16'sd8192);
      add(0, 0, -16'sd4096, 1'b1, 16'd1, 12, 16'sd16384);
      add(0, 0, -16'sd4096, 1'b1, 16'd1, 12, 16'sd24576);
      add(0, 0, -16'sd4096, 1'b1, 16'd1, 12, 16'sd32767);
      add(0, 0, -16'sd4096, 1'b1, 16'd1, 12, 16'sd32767);
      // first noise sample after reset
      add(1, 1, 16'sd0, 1'b0, 16'd0, 16, -16'sd2660);
      // voiced with zero period, then period 2 starting from a held counter
      add(1, 1, 16'sd0, 1'b1, 16'd0, 16, 16'sd0);
      add(0, 0, 16'sd0, 1'b1, 16'd0, 16, 16'sd0);
      add(0, 1, 16'sd0, 1'b1, 16'd2, 16, 16'sd8192);
      add(0, 0, 16'sd0, 1'b1, 16'd2, 16, 16'sd0);
      add(0, 0, 16'sd0, 1'b1, 16'd2, 16, 16'sd8192);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst_first) begin
            drain();
            if (i > 0) check("no_ovr_min_spacing", bus.ovr, 0);
            do_reset();
         end
         if (tbl[i].do_load) load_par(tbl[i].a1, tbl[i].voiced, tbl[i].fc);
         req(1'b1, tbl[i].exp_y, (tbl[i].space > LAT) ? tbl[i].space : LAT);
      end
      drain();

      // coefficient reload while a sample is in flight
      do_reset();
      load_par(-16'sd2048, 1'b1, 16'd100);
      req(1'b1, 16'sd8192, 16);
      req(1'b1, 16'sd4096, 4);
      load_par(16'sd0, 1'b1, 16'd100);
      repeat (12) @(negedge clk);
      req(1'b1, 16'sd0, 16);
      drain();

      // overrun: second request 5 cycles later is dropped
      do_reset();
      load_par(16'sd0, 1'b1, 16'd100);
      nv0 = nvout;
      req(1'b1, 16'sd8192, 5);
      req(1'b0, 16'sd0, 16);
      drain();
      check("overrun_single_vout", nvout - nv0, 1);
      check("overrun_ovr_set", bus.ovr, 1);

      // reset asserted mid-MAC aborts the sample
      nv0 = nvout;
      req(1'b0, 16'sd0, 8);
      rst = 1'b0;
      dm = 16'sd0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      check("abort_no_vout", nvout - nv0, 0);
      check("abort_y", bus.y, 0);
      check("abort_ovr_cleared", bus.ovr, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lpc_dec.md
LPC_DEC -- requirements
Module: lpc_dec

Interface
REQ-001 Parameter PULSE_AMP, default 16'sd8192, signed amplitude of the voiced excitation pulse.
REQ-002 Parameter NOISE_SHIFT, default 3, arithmetic right shift applied to the LFSR word to form unvoiced excitation.
REQ-003 Port clk  input  1  single clock for the block; all state updates on posedge.
REQ-004 Port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 Port A1..A10  input  16 each  signed predictor coefficients, Q3.12 (4096 = 1.0); A0 is implicitly 1.0 and has no port.
REQ-006 Port voiced  input  1  frame class: 1 selects pulse excitation, 0 selects noise.
REQ-007 Port freq_count  input  16  pitch period in samples (unsigned).
REQ-008 Port load  input  1  one-cycle strobe; captures A1..A10, voiced and freq_count into shadow registers.
REQ-009 Port v  input  1  one-cycle sample request strobe.
REQ-010 Port y  output  16  signed synthesized speech sample.
REQ-011 Port vout  output  1  one-cycle strobe marking y valid.
REQ-012 Port ovr  output  1  sticky overrun flag.

Function
REQ-013 Synthesis: y[n] = sat16((e[n]<<12 - sum k=1..10 of Ak*y[n-k]) >>> 12), accumulator 40-bit signed, saturation to [-32768, 32767].
REQ-014 Single shared 16x16 multiplier; one tap per cycle.
REQ-015 FSM states IDLE, MAC, OUT; IDLE->MAC on v; MAC holds 10 cycles (taps 1..10); MAC->OUT; OUT->IDLE.
REQ-016 v high at edge N (state IDLE) -> y and vout=1 registered at edge N+12; vout high exactly one cycle.
REQ-017 v sampled while state is not IDLE is ignored and sets ovr to 1; ovr cleared only by reset.
REQ-018 v accepted at edge N+12 (return to IDLE) is legal; minimum sample spacing 12 cycles.
REQ-019 load may arrive in any state; active coefficients/params copied from shadow on v acceptance, so a sample in flight never mixes coefficient sets.
REQ-020 Pitch counter: reset to 0; on each accepted v, if active voiced=1 and freq_count!=0, e=PULSE_AMP when counter==0 else 0; counter increments, wraps to 0 at freq_count-1.
REQ-021 freq_count==0 with voiced=1: e=0, counter held at 0.
REQ-022 Unvoiced: e = $signed(lfsr) >>> NOISE_SHIFT using current LFSR value; LFSR then advances.
REQ-023 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1; advances only on accepted v with voiced=0.
REQ-024 History y[n-1..n-10] shifts on edge N+12 with the saturated (pre-de-emphasis) result.

Reset
REQ-025 rst low: y=0, vout=0, ovr=0, state IDLE, history=0, pitch counter=0, LFSR=16'hACE1, shadow and active registers=0; takes effect immediately, including mid-MAC (no vout for the aborted sample).

Configuration
REQ-026 Macro LPC_DEC_DEEMPH_EN defined: output de-emphasis d[n] = sat16(y[n] + ((7*d[n-1]) >>> 3)), y port carries d[n], one extra OUT cycle, latency 13 cycles, minimum spacing 13; d state reset to 0.
REQ-027 Macro undefined: y carries filter output directly, latency 12 cycles.

Verification
REQ-028 Impulse train: A=0, voiced=1, freq_count=4, v every 16 cycles -> y = 8192,0,0,0,8192,..., each vout 12 cycles after v.
REQ-029 One-pole: A1=-2048, others 0, voiced=1, freq_count=100 -> y = 8192,4096,2048,1024,512.
REQ-030 Saturation: A1=-4096, voiced=1, freq_count=1 -> y = 8192,16384,24576,32767,32767.
REQ-031 Noise: A=0, voiced=0 after reset -> first y = -2660 (16'hACE1 >>> 3).
REQ-032 Overrun/reset: v at N and N+5 -> one vout, ovr=1; rst low at N+7 -> no vout, y=0, ovr=0.
REQ-033 With LPC_DEC_DEEMPH_EN, A=0, voiced=1, freq_count=100 -> y = 8192,7168,6272, vout 13 cycles after v.
